// File: rtl/archel_pkg.sv
// Shared opcode constants, instruction field positions and fetch/decode FSM encodings.
// Pure declarations; no logic or latency.
// Imported by the fetch/decode top and its field-split helper.
package archel_pkg;

    localparam int INSTR_W = 16;

    // Field bit positions inside the 16-bit instruction word
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 9;
    localparam int SRC_MSB = 8;
    localparam int SRC_LSB = 6;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    // Opcode map
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_MOV    = 4'h1;
    localparam logic [3:0] OP_ADD    = 4'h2;
    localparam logic [3:0] OP_SUB    = 4'h3;
    localparam logic [3:0] OP_AND    = 4'h4;
    localparam logic [3:0] OP_OR     = 4'h5;
    localparam logic [3:0] OP_XOR    = 4'h6;
    localparam logic [3:0] OP_SHL    = 4'h7;
    localparam logic [3:0] OP_SHR    = 4'h8;
    localparam logic [3:0] OP_LDI    = 4'h9;
    localparam logic [3:0] OP_LD     = 4'hA;
    localparam logic [3:0] OP_ST     = 4'hB;
    localparam logic [3:0] OP_RSV_LO = 4'hC;
    localparam logic [3:0] OP_RSV_HI = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] reg_dst;
        logic [2:0] reg_src;
        logic [5:0] imm;
    } instr_t;

    // Opcodes 0xC..0xE are reserved; they trap when the trap feature is built in
    function automatic logic is_reserved_op(input logic [3:0] op);
        return (op >= OP_RSV_LO) && (op <= OP_RSV_HI);
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// Splits a raw 16-bit instruction word into opcode/dst/src/imm fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module instr_field_split
    import archel_pkg::*;
(
    input  logic [INSTR_W-1:0] word,
    output instr_t             fields
);

    assign fields.opcode  = word[OPC_MSB:OPC_LSB];
    assign fields.reg_dst = word[DST_MSB:DST_LSB];
    assign fields.reg_src = word[SRC_MSB:SRC_LSB];
    assign fields.imm     = word[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch + decode: one request at a time to imem, decoded word offered to execute.
// Latency: imem_ack to dec_valid is 1 cycle; next imem_req 1 cycle after dec handshake.
// Backpressure: dec_valid/dec_* held until dec_ready; no new fetch while an instruction is offered.
// Optional feature macro ARCHEL_ILLEGAL_TRAP_EN: reserved opcodes 0xC-0xE trap (illegal pulse, halt).
module instr_fetch_decode
    import archel_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [3:0]        dec_opcode,
    output logic [2:0]        dec_reg_dst,
    output logic [2:0]        dec_reg_src,
    output logic [5:0]        dec_imm,
    output logic [PC_W-1:0]   dec_pc,
    output logic              halted,
    output logic              illegal
);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] addr_hold;   // address of the in-flight request while its data is to be discarded
    logic            discard;
    instr_t          split;
    instr_t          dec_q;
    logic [PC_W-1:0] dec_pc_q;

    logic fetch_ack;
    logic accept;
    logic trap;
    logic issue_take;

    instr_field_split u_split (
        .word   (imem_rdata),
        .fields (split)
    );

    // An ack only counts in FETCH; it is swallowed if a redirect is pending or arrives with it
    assign fetch_ack  = (state == ST_FETCH) && imem_ack;
    assign accept     = fetch_ack && !discard && !redirect_valid;
    assign issue_take = accept && !trap;

`ifdef ARCHEL_ILLEGAL_TRAP_EN
    logic illegal_q;

    assign trap    = accept && is_reserved_op(split.opcode);
    assign illegal = illegal_q;

    // One-cycle illegal pulse, the cycle after the trapping ack
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= trap;
        end
    end
`else
    assign trap    = 1'b0;
    assign illegal = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dec_valid = 1'b0;
        halted    = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (trap) begin
                    state_nxt = ST_HALT;
                end else if (issue_take) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dec_valid = 1'b1;
                // Redirect wins over a halt handshake so the core keeps running at the target
                if (redirect_valid) begin
                    state_nxt = ST_FETCH;
                end else if (dec_ready) begin
                    state_nxt = (dec_q.opcode == OP_HALT) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (redirect_valid) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    // Program counter, discard tracking and decoded-instruction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            addr_hold <= RESET_PC;
            discard   <= 1'b0;
            dec_q     <= '0;
            dec_pc_q  <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (accept) begin
                pc <= pc + 1'b1;
            end

            // The request in flight cannot be cancelled: keep its address on the bus
            // and drop its data when it returns, then refetch from the new pc.
            if (state == ST_FETCH) begin
                if (imem_ack) begin
                    discard <= 1'b0;
                end else if (redirect_valid && !discard) begin
                    discard   <= 1'b1;
                    addr_hold <= pc;
                end
            end

            if (issue_take) begin
                dec_q    <= split;
                dec_pc_q <= pc;
            end
        end
    end

    assign imem_addr   = discard ? addr_hold : pc;
    assign dec_opcode  = dec_q.opcode;
    assign dec_reg_dst = dec_q.reg_dst;
    assign dec_reg_src = dec_q.reg_src;
    assign dec_imm     = dec_q.imm;
    assign dec_pc      = dec_pc_q;

endmodule
